// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_pkg
// Brief    : Shared state encoding and constants for the display bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    localparam int DEF_DATA_W = 32;

    // Read data returned to a master whose transaction timed out
    localparam int unsigned ERR_RDATA = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/seven_seg_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_rr_pick
// Brief    : Combinational two-way grant. Round-robin by default; fixed
//            priority to master 0 when SEVEN_SEG_ARB_FIXED_PRIO_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_rr_pick (
    input  logic i_m0_stb,
    input  logic i_m1_stb,
    input  logic i_last_grant,
    output logic o_grant,
    output logic o_valid
);

`ifdef SEVEN_SEG_ARB_FIXED_PRIO_EN
    logic w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;

    always_comb begin
        o_valid = i_m0_stb | i_m1_stb;
        o_grant = ~i_m0_stb & i_m1_stb;
    end
`else
    always_comb begin
        o_valid = i_m0_stb | i_m1_stb;
        // On a tie the master that did not win last time goes next
        if (i_m0_stb && i_m1_stb) begin
            o_grant = ~i_last_grant;
        end else begin
            o_grant = i_m1_stb;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/seven_seg_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_bus_arb
// Brief    : Two-master arbiter for the seven-segment display slave bus with
//            a slave timeout guard. Option: SEVEN_SEG_ARB_FIXED_PRIO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_bus_arb
    import seven_seg_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic [DATA_W-1:0] m0_dat_o,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              m1_ack,
    output logic              m1_err,
    output logic              s_stb,
    output logic              s_we,
    output logic [DATA_W-1:0] s_dat_o,
    input  logic [DATA_W-1:0] s_dat_i,
    input  logic              s_ack
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_last_grant;
    logic              r_grant;
    logic              r_err;
    logic [7:0]        r_cnt;
    logic              r_s_we;
    logic [DATA_W-1:0] r_s_dat;
    logic [DATA_W-1:0] r_m0_dat;
    logic [DATA_W-1:0] r_m1_dat;
    logic              w_pick_grant;
    logic              w_pick_valid;
    logic              w_timeout;

    seven_seg_rr_pick u_pick (
        .i_m0_stb     (m0_stb),
        .i_m1_stb     (m1_stb),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick_grant),
        .o_valid      (w_pick_valid)
    );

    assign w_timeout = (r_cnt == CNT_LAST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_pick_valid) w_next_state = REQ;
            REQ:     if (s_ack || w_timeout) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
            r_s_we       <= 1'b0;
            r_s_dat      <= '0;
            r_m0_dat     <= '0;
            r_m1_dat     <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    r_err <= 1'b0;
                    if (w_pick_valid) begin
                        r_grant <= w_pick_grant;
                        r_s_we  <= w_pick_grant ? m1_we    : m0_we;
                        r_s_dat <= w_pick_grant ? m1_dat_i : m0_dat_i;
                    end
                end
                REQ: begin
                    if (s_ack) begin
                        r_cnt        <= '0;
                        r_last_grant <= r_grant;
                        if (r_grant) r_m1_dat <= s_dat_i;
                        else         r_m0_dat <= s_dat_i;
                    end else if (w_timeout) begin
                        // A hung slave does not consume the master's turn
                        r_cnt <= '0;
                        r_err <= 1'b1;
                        if (r_grant) r_m1_dat <= DATA_W'(ERR_RDATA);
                        else         r_m0_dat <= DATA_W'(ERR_RDATA);
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign s_stb    = (r_state == REQ);
    assign s_we     = r_s_we;
    assign s_dat_o  = r_s_dat;
    assign m0_dat_o = r_m0_dat;
    assign m1_dat_o = r_m1_dat;
    assign m0_ack   = (r_state == DONE) && !r_grant && !r_err;
    assign m0_err   = (r_state == DONE) && !r_grant &&  r_err;
    assign m1_ack   = (r_state == DONE) &&  r_grant && !r_err;
    assign m1_err   = (r_state == DONE) &&  r_grant &&  r_err;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_bus_arb
// Brief    : Self-checking bench for seven_seg_bus_arb with a behavioural slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_bus_arb;

    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_stb, m0_we, m1_stb, m1_we;
    logic [DATA_W-1:0] m0_dat_i, m0_dat_o, m1_dat_i, m1_dat_o;
    logic              m0_ack, m0_err, m1_ack, m1_err;
    logic              s_stb, s_we, s_ack;
    logic [DATA_W-1:0] s_dat_o, s_dat_i;

    int                slv_wait  = 0;
    bit                slv_hang  = 1'b0;
    logic [DATA_W-1:0] slv_rdata = '0;
    int                stb_cnt   = 0;

    int                checks = 0;
    int                errors = 0;

    bit                mdl_last;
    logic [DATA_W-1:0] mdl_dat [2];

    always #5 clk = ~clk;

    seven_seg_bus_arb #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_stb   (m0_stb),
        .m0_we    (m0_we),
        .m0_dat_i (m0_dat_i),
        .m0_dat_o (m0_dat_o),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m1_stb   (m1_stb),
        .m1_we    (m1_we),
        .m1_dat_i (m1_dat_i),
        .m1_dat_o (m1_dat_o),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .s_stb    (s_stb),
        .s_we     (s_we),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),
        .s_ack    (s_ack)
    );

    // Slave acks after slv_wait strobe cycles; data is valid only with ack
    assign s_ack   = s_stb && !slv_hang && (stb_cnt == slv_wait);
    assign s_dat_i = s_ack ? slv_rdata : ~slv_rdata;

    always @(posedge clk) stb_cnt <= s_stb ? stb_cnt + 1 : 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] resp_vec();
        return 32'({m0_ack, m0_err, m1_ack, m1_err});
    endfunction

    // Entered at the falling edge of an IDLE cycle with at least one stb high
    task automatic do_txn(input bit drop_early, input int wcyc, input bit hang,
                          input logic [DATA_W-1:0] rdata);
        int                w;
        int                n_stb;
        bit                done;
        logic              exp_we;
        logic [DATA_W-1:0] exp_dat;
        logic [3:0]        exp_resp;
        slv_wait  = wcyc;
        slv_hang  = hang;
        slv_rdata = rdata;
`ifdef SEVEN_SEG_ARB_FIXED_PRIO_EN
        if (m0_stb && m1_stb) w = 0;
`else
        if (m0_stb && m1_stb) w = mdl_last ? 0 : 1;
`endif
        else w = m1_stb ? 1 : 0;
        exp_we  = (w == 1) ? m1_we : m0_we;
        exp_dat = (w == 1) ? m1_dat_i : m0_dat_i;
        n_stb = 0;
        done  = 1'b0;
        for (int k = 0; k < TIMEOUT + 12 && !done; k++) begin
            @(negedge clk);
            if (s_stb) begin
                if (n_stb == 0) begin
                    chk("s_we", 32'(s_we), 32'(exp_we));
                    chk("s_dat_o", s_dat_o, exp_dat);
                    if (drop_early) begin
                        if (w == 1) m1_stb = 1'b0;
                        else        m0_stb = 1'b0;
                    end
                end
                chk("resp_during_req", resp_vec(), 32'd0);
                n_stb++;
            end else begin
                done = 1'b1;
            end
        end
        chk("txn_bound", 32'(done), 32'd1);
        chk("s_stb_cycles", 32'(n_stb), hang ? 32'(TIMEOUT) : 32'(wcyc + 1));
        exp_resp = (w == 1) ? {2'b00, !hang, hang} : {!hang, hang, 2'b00};
        chk("ack_err", resp_vec(), 32'(exp_resp));
        if (!hang) mdl_last = w[0];
        mdl_dat[w] = hang ? '0 : rdata;
        chk("m0_dat_o", m0_dat_o, mdl_dat[0]);
        chk("m1_dat_o", m1_dat_o, mdl_dat[1]);
        if (w == 1) m1_stb = 1'b0;
        else        m0_stb = 1'b0;
        @(negedge clk);
        chk("idle_quiet", resp_vec() | 32'(s_stb), 32'd0);
    endtask

    initial begin
        bit r0, r1;
        rst = 1'b1;
        m0_stb = 1'b0; m0_we = 1'b0; m0_dat_i = '0;
        m1_stb = 1'b0; m1_we = 1'b0; m1_dat_i = '0;
        mdl_last = 1'b1;
        mdl_dat[0] = '0;
        mdl_dat[1] = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_s_stb", 32'(s_stb), 32'd0);
        chk("rst_s_we", 32'(s_we), 32'd0);
        chk("rst_s_dat_o", s_dat_o, 32'd0);
        chk("rst_resp", resp_vec(), 32'd0);
        chk("rst_m0_dat", m0_dat_o, 32'd0);
        chk("rst_m1_dat", m1_dat_o, 32'd0);
        rst = 1'b0;

        // Single write from master 0
        m0_stb = 1'b1; m0_we = 1'b1; m0_dat_i = 32'h0000_1234;
        do_txn(1'b0, 0, 1'b0, $urandom);

        // Read from master 1
        m1_stb = 1'b1; m1_we = 1'b0; m1_dat_i = $urandom;
        do_txn(1'b0, 0, 1'b0, 32'h0000_00C0);

        // Contention: both masters keep requesting
        for (int i = 0; i < 4; i++) begin
            m0_stb = 1'b1; m0_we = $urandom; m0_dat_i = $urandom;
            m1_stb = 1'b1; m1_we = $urandom; m1_dat_i = $urandom;
            do_txn(1'b0, 0, 1'b0, $urandom);
        end
        m0_stb = 1'b0; m1_stb = 1'b0;
        @(negedge clk);

        // Reset in the middle of a transaction against a hung slave
        slv_hang = 1'b1;
        m0_stb = 1'b1; m0_we = 1'b1; m0_dat_i = $urandom;
        @(negedge clk);
        chk("pre_rst_s_stb", 32'(s_stb), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_s_stb", 32'(s_stb), 32'd0);
        chk("mid_rst_resp", resp_vec(), 32'd0);
        chk("mid_rst_m0_dat", m0_dat_o, 32'd0);
        chk("mid_rst_m1_dat", m1_dat_o, 32'd0);
        rst = 1'b0;
        m0_stb = 1'b0;
        mdl_last = 1'b1;
        mdl_dat[0] = '0;
        mdl_dat[1] = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("after_rst_quiet", resp_vec() | 32'(s_stb), 32'd0);
        end
        m0_stb = 1'b1; m0_we = 1'b0; m0_dat_i = $urandom;
        do_txn(1'b0, 0, 1'b0, $urandom);

        // Timeout on master 0, then a contest
        m0_stb = 1'b1; m0_we = 1'b1; m0_dat_i = $urandom;
        do_txn(1'b0, 0, 1'b1, $urandom);
        m0_stb = 1'b1; m0_we = $urandom; m0_dat_i = $urandom;
        m1_stb = 1'b1; m1_we = $urandom; m1_dat_i = $urandom;
        do_txn(1'b0, 1, 1'b0, $urandom);

        // Slave with three wait states
        m0_stb = 1'b1; m0_we = 1'b0; m0_dat_i = $urandom;
        do_txn(1'b0, 3, 1'b0, $urandom);

        // Randomized traffic, including early stb drops and timeouts
        for (int i = 0; i < 24; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1 && !m0_stb && !m1_stb) r0 = 1'b1;
            m0_stb = m0_stb | r0;
            m1_stb = m1_stb | r1;
            m0_we = $urandom; m0_dat_i = $urandom;
            m1_we = $urandom; m1_dat_i = $urandom;
            do_txn(1'($urandom_range(0, 1)), $urandom_range(0, 4),
                   ($urandom_range(0, 7) == 0), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
